// File: rtl/spi_master_mc.sv
`default_nettype none
// ============================================================================
// Module      : spi_master_mc
// Description : Multi-chip-select SPI master. One engine serves NUM_CS
//               active-low slave selects with per-frame CPOL/CPHA,
//               programmable SCLK half-period, CS hold across frames and
//               abort. Frames run IDLE -> SETUP -> XFER -> TRAIL -> IDLE.
//               Optional macro SPI_LSB_FIRST_EN selects LSB-first shifting
//               (default build shifts MSB first).
// Revision    : 1.0 - initial release
// ============================================================================
module spi_master_mc #(
  parameter int DATA_W = 8,
  parameter int NUM_CS = 2,
  parameter int DIV_W  = 8,
  localparam int CS_W  = (NUM_CS > 1) ? $clog2(NUM_CS) : 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              abort,
  input  logic [DATA_W-1:0] tx_data,
  input  logic [CS_W-1:0]   cs_sel,
  input  logic              cpol,
  input  logic              cpha,
  input  logic [DIV_W-1:0]  clk_div,
  input  logic              hold_cs,
  output logic              busy,
  output logic              done,
  output logic              cs_err,
  output logic [DATA_W-1:0] rx_data,
  output logic              sclk,
  output logic              mosi,
  input  logic              miso,
  output logic [NUM_CS-1:0] ss_n
);

  // Number of SCLK edges per frame and the counter width needed to hold it
  localparam int c_EDGES  = 2 * DATA_W;
  localparam int c_EDGE_W = $clog2(c_EDGES + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SETUP = 2'd1,
    S_XFER  = 2'd2,
    S_TRAIL = 2'd3
  } state_t;

  state_t                r_state;
  state_t                w_next_state;

  // Settings captured at accept so the CPU may change inputs mid-frame
  logic [DIV_W-1:0]      r_div;
  logic                  r_cpol;
  logic                  r_cpha;
  logic                  r_hold;
  logic                  r_cs_bad;

  logic [DIV_W-1:0]      r_cnt;
  logic [c_EDGE_W-1:0]   r_edge;
  logic [DATA_W-1:0]     r_tx_sr;
  logic [DATA_W-1:0]     r_rx_sr;
  logic [DATA_W-1:0]     r_rx_data;
  logic                  r_sclk;
  logic                  r_mosi;
  logic [NUM_CS-1:0]     r_ss_n;
  logic                  r_done;
  logic                  r_cs_err;

  logic                  w_tick;
  logic                  w_accept;
  logic                  w_edge_evt;
  logic                  w_last_edge;
  logic                  w_frame_end;
  logic                  w_lead;
  logic                  w_sample;
  logic                  w_shift;
  logic                  w_sel_bad;
  logic [NUM_CS-1:0]     w_sel_mask;

`ifdef SPI_LSB_FIRST_EN
  function automatic logic first_bit(input logic [DATA_W-1:0] v);
    return v[0];
  endfunction

  function automatic logic [DATA_W-1:0] tx_shift(input logic [DATA_W-1:0] v);
    return v >> 1;
  endfunction

  // First received bit ends up in bit 0 after DATA_W samples
  function automatic logic [DATA_W-1:0] rx_shift(input logic [DATA_W-1:0] v,
                                                 input logic b);
    return {b, v[DATA_W-1:1]};
  endfunction
`else
  function automatic logic first_bit(input logic [DATA_W-1:0] v);
    return v[DATA_W-1];
  endfunction

  function automatic logic [DATA_W-1:0] tx_shift(input logic [DATA_W-1:0] v);
    return v << 1;
  endfunction

  function automatic logic [DATA_W-1:0] rx_shift(input logic [DATA_W-1:0] v,
                                                 input logic b);
    return {v[DATA_W-2:0], b};
  endfunction
`endif

  // Half-period tick and edge classification; edge number is r_edge+1,
  // so an even r_edge marks an odd (leading) SCLK edge
  assign w_tick      = (r_cnt == r_div);
  assign w_accept    = (r_state == S_IDLE) && start && !abort;
  assign w_edge_evt  = (r_state == S_XFER) && w_tick;
  assign w_last_edge = w_edge_evt && (r_edge == c_EDGE_W'(c_EDGES - 1));
  assign w_frame_end = (r_state == S_TRAIL) && w_tick;
  assign w_lead      = ~r_edge[0];
  assign w_sample    = w_edge_evt && (r_cpha ? !w_lead : w_lead);
  assign w_shift     = w_edge_evt && (r_cpha ? w_lead : !w_lead);
  assign w_sel_bad   = (int'(cs_sel) >= NUM_CS);

  // Decode the requested slave index; an out-of-range index selects nobody
  always_comb begin
    w_sel_mask = '0;
    for (int i = 0; i < NUM_CS; i++) begin
      if (int'(cs_sel) == i) begin
        w_sel_mask[i] = 1'b1;
      end
    end
  end

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic; abort overrides everything, including a same-cycle start
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  if (w_accept)    w_next_state = S_SETUP;
      S_SETUP: if (w_tick)      w_next_state = S_XFER;
      S_XFER:  if (w_last_edge) w_next_state = S_TRAIL;
      S_TRAIL: if (w_tick)      w_next_state = S_IDLE;
      default:                  w_next_state = S_IDLE;
    endcase
    if (abort) begin
      w_next_state = S_IDLE;
    end
  end

  // Half-period divider and SCLK edge counter
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt  <= '0;
      r_edge <= '0;
    end else if (abort || w_accept) begin
      r_cnt  <= '0;
      r_edge <= '0;
    end else if (r_state != S_IDLE) begin
      if (w_tick) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + DIV_W'(1);
      end
      if (w_edge_evt) begin
        r_edge <= r_edge + c_EDGE_W'(1);
      end
    end
  end

  // Frame settings latched on accept
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_div    <= '0;
      r_cpol   <= 1'b0;
      r_cpha   <= 1'b0;
      r_hold   <= 1'b0;
      r_cs_bad <= 1'b0;
    end else if (w_accept) begin
      r_div    <= clk_div;
      r_cpol   <= cpol;
      r_cpha   <= cpha;
      r_hold   <= hold_cs;
      r_cs_bad <= w_sel_bad;
    end
  end

  // Pin drivers, shift registers and completion pulses
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_tx_sr   <= '0;
      r_rx_sr   <= '0;
      r_rx_data <= '0;
      r_sclk    <= 1'b0;
      r_mosi    <= 1'b0;
      r_ss_n    <= '1;
      r_done    <= 1'b0;
      r_cs_err  <= 1'b0;
    end else begin
      r_done   <= 1'b0;
      r_cs_err <= 1'b0;
      if (abort) begin
        r_ss_n <= '1;
        r_sclk <= r_cpol;
        r_mosi <= 1'b0;
      end else if (w_accept) begin
        // New select replaces any CS held from the previous frame
        r_ss_n  <= ~w_sel_mask;
        r_sclk  <= cpol;
        r_rx_sr <= '0;
        if (cpha) begin
          r_mosi  <= 1'b0;
          r_tx_sr <= tx_data;
        end else begin
          r_mosi  <= first_bit(tx_data);
          r_tx_sr <= tx_shift(tx_data);
        end
      end else begin
        if (w_edge_evt) begin
          r_sclk <= ~r_sclk;
        end
        if (w_shift) begin
          r_mosi  <= first_bit(r_tx_sr);
          r_tx_sr <= tx_shift(r_tx_sr);
        end
        if (w_sample) begin
          r_rx_sr <= rx_shift(r_rx_sr, miso);
        end
        if (w_frame_end) begin
          r_done    <= 1'b1;
          r_cs_err  <= r_cs_bad;
          r_rx_data <= r_rx_sr;
          if (!r_hold) begin
            r_ss_n <= '1;
          end
        end
      end
    end
  end

  assign busy    = (r_state != S_IDLE);
  assign done    = r_done;
  assign cs_err  = r_cs_err;
  assign rx_data = r_rx_data;
  assign sclk    = r_sclk;
  assign mosi    = r_mosi;
  assign ss_n    = r_ss_n;

endmodule
`default_nettype wire

// File: tb/tb_spi_master_mc.sv
`default_nettype none
// ============================================================================
// Module      : tb_spi_master_mc
// Description : Directed self-checking bench for spi_master_mc. Uses
//               NUM_CS=3 so that cs_sel (2 bits) can address a missing
//               slave; select patterns are therefore 3 bits wide.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_master_mc;

  localparam int DATA_W = 8;
  localparam int NUM_CS = 3;
  localparam int DIV_W  = 8;

  logic              clk     = 1'b0;
  logic              reset_n = 1'b0;
  logic              start   = 1'b0;
  logic              abort   = 1'b0;
  logic [DATA_W-1:0] tx_data = '0;
  logic [1:0]        cs_sel  = '0;
  logic              cpol    = 1'b0;
  logic              cpha    = 1'b0;
  logic [DIV_W-1:0]  clk_div = '0;
  logic              hold_cs = 1'b0;
  logic              busy;
  logic              done;
  logic              cs_err;
  logic [DATA_W-1:0] rx_data;
  logic              sclk;
  logic              mosi;
  logic              miso;
  logic [NUM_CS-1:0] ss_n;

  int n_checks = 0;
  int n_fail   = 0;

  // Frame observations filled in by run_frame
  int                f_done_cyc;
  int                f_ss_first;
  int                f_ss_last;
  int                f_edges;
  logic              f_err;
  logic              f_busy_done;
  logic [NUM_CS-1:0] f_ss_mid;

  // Slave model: loopback or a mode-3 shift register slave
  logic       loop_en  = 1'b1;
  logic       slv_en   = 1'b0;
  logic       slv_miso = 1'b0;
  logic [7:0] slv_tx   = '0;
  logic [7:0] slv_rx   = '0;

  spi_master_mc #(
    .DATA_W (DATA_W),
    .NUM_CS (NUM_CS),
    .DIV_W  (DIV_W)
  ) u_dut (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (start),
    .abort   (abort),
    .tx_data (tx_data),
    .cs_sel  (cs_sel),
    .cpol    (cpol),
    .cpha    (cpha),
    .clk_div (clk_div),
    .hold_cs (hold_cs),
    .busy    (busy),
    .done    (done),
    .cs_err  (cs_err),
    .rx_data (rx_data),
    .sclk    (sclk),
    .mosi    (mosi),
    .miso    (miso),
    .ss_n    (ss_n)
  );

  always #5 clk = ~clk;

  assign miso = loop_en ? mosi : slv_miso;

  // Mode-3 slave: drive on falling (leading) edge, capture on rising edge
  always @(negedge sclk) begin
    if (slv_en) begin
      slv_miso = slv_tx[7];
      slv_tx   = {slv_tx[6:0], 1'b0};
    end
  end

  always @(posedge sclk) begin
    if (slv_en) begin
      slv_rx = {slv_rx[6:0], mosi};
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Called just after a rising edge. Start is high in cycle 0, accepted at
  // the next edge; cycle c is the period following edge c.
  task automatic run_frame(input logic [7:0] tx, input logic [1:0] cs,
                           input logic pol, input logic pha,
                           input logic [7:0] div, input logic hold);
    logic prev;
    prev        = 1'b0;
    tx_data     = tx;
    cs_sel      = cs;
    cpol        = pol;
    cpha        = pha;
    clk_div     = div;
    hold_cs     = hold;
    start       = 1'b1;
    @(posedge clk);
    #1 start    = 1'b0;
    f_done_cyc  = -1;
    f_ss_first  = -1;
    f_ss_last   = -1;
    f_edges     = 0;
    f_err       = 1'b0;
    f_busy_done = 1'b1;
    f_ss_mid    = '0;
    for (int c = 1; c <= 600; c++) begin
      @(negedge clk);
      if (c == 1) begin
        prev = sclk;
      end else if (sclk !== prev) begin
        f_edges++;
        prev = sclk;
      end
      if (c == 2) f_ss_mid = ss_n;
      if (int'(cs) < NUM_CS) begin
        if (ss_n[cs] === 1'b0) begin
          if (f_ss_first < 0) f_ss_first = c;
          f_ss_last = c;
        end
      end
      if (done === 1'b1) begin
        f_done_cyc  = c;
        f_err       = cs_err;
        f_busy_done = busy;
        break;
      end
    end
    if (f_done_cyc < 0) check("frame_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int   seen;
    int   edges;
    logic prev;
    logic hold_ok;

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy",   busy,    1'b0);
    check("rst_done",   done,    1'b0);
    check("rst_cs_err", cs_err,  1'b0);
    check("rst_rx",     rx_data, 8'h00);
    check("rst_sclk",   sclk,    1'b0);
    check("rst_mosi",   mosi,    1'b0);
    check("rst_ss_n",   ss_n,    3'b111);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    // Mode 0, H=2, loopback
    run_frame(8'hA5, 2'd0, 1'b0, 1'b0, 8'd1, 1'b0);
    check("m0_rx",        rx_data,     8'hA5);
    check("m0_done_cyc",  f_done_cyc,  32'd37);
    check("m0_ss_first",  f_ss_first,  32'd1);
    check("m0_ss_last",   f_ss_last,   32'd36);
    check("m0_edges",     f_edges,     32'd16);
    check("m0_busy_done", f_busy_done, 1'b0);
    check("m0_cs_err",    f_err,       1'b0);
    check("m0_ss_after",  ss_n,        3'b111);
    check("m0_done_1cyc", done,        1'b0);

    // Mode 3, H=1, slave returns 0xC3
    slv_tx  = 8'hC3;
    slv_rx  = 8'h00;
    loop_en = 1'b0;
    slv_en  = 1'b1;
    run_frame(8'h3C, 2'd0, 1'b1, 1'b1, 8'd0, 1'b0);
    slv_en  = 1'b0;
    loop_en = 1'b1;
    check("m3_rx",       rx_data,    8'hC3);
    check("m3_slave_rx", slv_rx,     8'h3C);
    check("m3_done_cyc", f_done_cyc, 32'd19);
    check("m3_edges",    f_edges,    32'd16);
    check("m3_sclk_idle", sclk,      1'b1);

    // Held CS on slave 1, then a frame to slave 0
    run_frame(8'h5A, 2'd1, 1'b0, 1'b0, 8'd0, 1'b1);
    check("hold_rx",  rx_data,  8'h5A);
    check("hold_mid", f_ss_mid, 3'b101);
    repeat (3) @(posedge clk);
    #1;
    check("hold_between", ss_n, 3'b101);
    check("hold_idle",    busy, 1'b0);
    run_frame(8'h81, 2'd0, 1'b0, 1'b0, 8'd0, 1'b0);
    check("next_mid",   f_ss_mid, 3'b110);
    check("next_rx",    rx_data,  8'h81);
    check("next_after", ss_n,     3'b111);

    // Select beyond NUM_CS
    run_frame(8'h66, 2'd3, 1'b0, 1'b0, 8'd0, 1'b0);
    check("bad_mid",      f_ss_mid,   3'b111);
    check("bad_err",      f_err,      1'b1);
    check("bad_done_cyc", f_done_cyc, 32'd19);
    check("bad_rx",       rx_data,    8'h66);

    // Abort while idle releases a held CS
    run_frame(8'h24, 2'd2, 1'b0, 1'b0, 8'd0, 1'b1);
    check("hold2_after", ss_n, 3'b011);
    abort = 1'b1;
    @(posedge clk);
    #1 abort = 1'b0;
    check("idle_abort_ss", ss_n, 3'b111);

    // Abort at XFER cycle 10 (cycle 12), with a competing start
    tx_data = 8'hF0;
    cs_sel  = 2'd0;
    cpol    = 1'b1;
    cpha    = 1'b0;
    clk_div = 8'd1;
    hold_cs = 1'b1;
    start   = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (11) @(posedge clk);
    #1;
    check("abort_pre_busy", busy, 1'b1);
    abort = 1'b1;
    start = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    start = 1'b0;
    @(negedge clk);
    check("abort_busy", busy, 1'b0);
    check("abort_ss",   ss_n, 3'b111);
    check("abort_sclk", sclk, 1'b1);
    check("abort_mosi", mosi, 1'b0);
    seen = 0;
    for (int c = 0; c < 50; c++) begin
      if (done === 1'b1) seen++;
      @(negedge clk);
    end
    check("abort_no_done", seen,    32'd0);
    check("abort_rx_keep", rx_data, 8'h24);
    check("abort_idle",    busy,    1'b0);

    // Start held high, reset mid-XFER
    @(posedge clk);
    #1;
    tx_data = 8'hC5;
    cs_sel  = 2'd0;
    cpol    = 1'b0;
    cpha    = 1'b0;
    clk_div = 8'd0;
    hold_cs = 1'b0;
    start   = 1'b1;
    @(posedge clk);
    #1;
    edges   = 0;
    prev    = 1'b0;
    hold_ok = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (c == 1) begin
        prev = sclk;
      end else if (sclk !== prev) begin
        edges++;
        prev = sclk;
      end
      if (busy !== 1'b1 || ss_n !== 3'b110) hold_ok = 1'b0;
    end
    check("one_accept_edges", edges,   32'd8);
    check("one_accept_busy",  hold_ok, 1'b1);
    #1 reset_n = 1'b0;
    #1;
    check("arst_busy", busy,    1'b0);
    check("arst_ss",   ss_n,    3'b111);
    check("arst_sclk", sclk,    1'b0);
    check("arst_mosi", mosi,    1'b0);
    check("arst_rx",   rx_data, 8'h00);
    check("arst_done", done,    1'b0);
    start = 1'b0;
    @(posedge clk);
    #1 reset_n = 1'b1;
    seen = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) seen++;
    end
    check("arst_quiet", seen, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
